// File: rtl/qtr_pkg.sv
// Shared definitions for the QTR line-sensor block: FSM state encoding and a
// constant-evaluable ceil(log2) helper used to size derived widths.
package qtr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHARGE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_SUM     = 3'd3,
    ST_DIVIDE  = 3'd4,
    ST_DONE    = 3'd5
  } qtr_state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int qtr_clog2(input int value);
    int res;
    int v;
    res = 32'sd0;
    v   = value - 32'sd1;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/qtr_div_seq.sv
// Restoring divider, one quotient bit per clock. The dividend must satisfy
// dividend >> Q_W < divisor (quotient fits in Q_W bits), so the partial
// remainder never needs more than DVS_W bits. The cycle that asserts start
// already produces the first quotient bit, so done pulses Q_W cycles after
// start with the quotient registered and stable from that cycle onward.
module qtr_div_seq
  import qtr_pkg::*;
#(
  parameter int DVS_W = 4,
  parameter int Q_W   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DVS_W+Q_W-1:0] dividend,
  input  logic [DVS_W-1:0]     divisor,
  output logic [Q_W-1:0]       quotient,
  output logic                 done
);

  localparam int CNT_W = qtr_clog2(Q_W + 1);

  logic [DVS_W-1:0] rem_r;
  logic [Q_W-1:0]   dvd_r;
  logic [Q_W-1:0]   q_r;
  logic [DVS_W-1:0] dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic             done_r;

  logic [DVS_W-1:0] step_rem_in;
  logic             step_bit_in;
  logic [DVS_W-1:0] step_dvs;
  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   diff;
  logic             q_bit;
  logic [DVS_W-1:0] rem_next;

  // Operand select: a fresh start seeds the first step straight from the inputs
  always_comb begin
    if (start) begin
      step_rem_in = dividend[DVS_W+Q_W-1:Q_W];
      step_bit_in = dividend[Q_W-1];
      step_dvs    = divisor;
    end else begin
      step_rem_in = rem_r;
      step_bit_in = dvd_r[Q_W-1];
      step_dvs    = dvs_r;
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    trial = {step_rem_in, step_bit_in};
    diff  = trial - {1'b0, step_dvs};
    if (trial >= {1'b0, step_dvs}) begin
      q_bit    = 1'b1;
      rem_next = diff[DVS_W-1:0];
    end else begin
      q_bit    = 1'b0;
      rem_next = trial[DVS_W-1:0];
    end
  end

  // Iteration registers and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r  <= '0;
      dvd_r  <= '0;
      q_r    <= '0;
      dvs_r  <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        rem_r <= rem_next;
        dvd_r <= {dividend[Q_W-2:0], 1'b0};
        q_r   <= {{(Q_W-1){1'b0}}, q_bit};
        dvs_r <= divisor;
        cnt_r <= CNT_W'(1);
        run_r <= 1'b1;
      end else if (run_r) begin
        rem_r <= rem_next;
        dvd_r <= {dvd_r[Q_W-2:0], 1'b0};
        q_r   <= {q_r[Q_W-2:0], q_bit};
        cnt_r <= cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(Q_W - 1)) begin
          run_r  <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign quotient = q_r;
  assign done     = done_r;

endmodule

// File: rtl/qtr_linea_param.sv
// QTR reflectance line sensor front end: charges the sensor capacitors, times
// each channel's decay, flags channels above threshold and reports the
// weighted centroid of active channels as unsigned fixed point.
// Build option: define QTR_LOST_HOLD_EN to keep the previous pos when a
// measurement finds no active channel (default build drives pos to 0).
module qtr_linea_param
  import qtr_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int CNT_W      = 12,
  parameter int CHARGE_CYC = 480,
  parameter int FRAC_W     = 7,
  localparam int IDX_W     = qtr_clog2(N_CH + 1),
  localparam int POS_W     = IDX_W + FRAC_W,
  localparam int SUM_W     = POS_W + IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [CNT_W-1:0] thresh,
  input  logic [N_CH-1:0]  sns_in,
  output logic [N_CH-1:0]  sns_oe,
  output logic [POS_W-1:0] pos,
  output logic [N_CH-1:0]  active_mask,
  output logic             line_lost,
  output logic             busy,
  output logic             done
);

  localparam int               CHG_W   = qtr_clog2(CHARGE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  qtr_state_e state_r;
  qtr_state_e state_nxt;

  logic [N_CH-1:0]  sync1_r;
  logic [N_CH-1:0]  sync2_r;
  logic [CHG_W-1:0] chg_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic [N_CH-1:0]  latched_r;
  logic [CNT_W-1:0] time_r [N_CH];
  logic [N_CH-1:0]  act_r;
  logic [N_CH-1:0]  sum_sh_r;
  logic [IDX_W-1:0] wgt_r;
  logic [SUM_W-1:0] acc_r;
  logic [IDX_W-1:0] n_r;

  logic             sns_oe_r;
  logic [POS_W-1:0] pos_r;
  logic [N_CH-1:0]  active_mask_r;
  logic             line_lost_r;
  logic             busy_r;
  logic             done_r;

  logic [N_CH-1:0]  latch_now;
  logic [N_CH-1:0]  act_fin;
  logic             chg_end;
  logic             meas_end;
  logic             sum_end;
  logic [SUM_W-1:0] acc_nxt;
  logic [IDX_W-1:0] n_nxt;
  logic             div_start;
  logic [POS_W-1:0] div_quot;
  logic             div_done;

  // Two-flop synchroniser for the asynchronous pad levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= sns_in;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel latch events and final on-line flags; an unlatched channel
  // at the end of MEASURE takes the current count (the saturation value)
  always_comb begin
    latch_now = '0;
    act_fin   = '0;
    for (int i = 0; i < N_CH; i++) begin
      latch_now[i] = ~latched_r[i] & ~sync2_r[i];
      if (latched_r[i]) begin
        act_fin[i] = (time_r[i] >= thresh);
      end else begin
        act_fin[i] = (cnt_r >= thresh);
      end
    end
  end

  // Phase-end conditions and the next accumulator values during SUM
  always_comb begin
    chg_end  = (chg_cnt_r == CHG_W'(CHARGE_CYC - 1));
    meas_end = (&(latched_r | latch_now)) || (cnt_r == CNT_MAX);
    sum_end  = (wgt_r == IDX_W'(N_CH));
    if (sum_sh_r[0]) begin
      acc_nxt = acc_r + (SUM_W'(wgt_r) << FRAC_W);
      n_nxt   = n_r + IDX_W'(1);
    end else begin
      acc_nxt = acc_r;
      n_nxt   = n_r;
    end
    if ((state_r == ST_SUM) && sum_end && (n_nxt != '0)) begin
      div_start = 1'b1;
    end else begin
      div_start = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start || cont) state_nxt = ST_CHARGE;
        else               state_nxt = ST_IDLE;
      end
      ST_CHARGE: begin
        if (chg_end) state_nxt = ST_MEASURE;
        else         state_nxt = ST_CHARGE;
      end
      ST_MEASURE: begin
        if (meas_end) state_nxt = ST_SUM;
        else          state_nxt = ST_MEASURE;
      end
      ST_SUM: begin
        if (!sum_end)             state_nxt = ST_SUM;
        else if (n_nxt == '0)     state_nxt = ST_DONE;
        else                      state_nxt = ST_DIVIDE;
      end
      ST_DIVIDE: begin
        if (div_done) state_nxt = ST_DONE;
        else          state_nxt = ST_DIVIDE;
      end
      ST_DONE: begin
        if (cont) state_nxt = ST_CHARGE;
        else      state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Measurement datapath: charge timer, decay counter, latches, centroid sums
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt_r <= '0;
      cnt_r     <= '0;
      latched_r <= '0;
      act_r     <= '0;
      sum_sh_r  <= '0;
      wgt_r     <= '0;
      acc_r     <= '0;
      n_r       <= '0;
      for (int i = 0; i < N_CH; i++) time_r[i] <= '0;
    end else begin
      case (state_r)
        ST_CHARGE: begin
          if (chg_end) chg_cnt_r <= '0;
          else         chg_cnt_r <= chg_cnt_r + CHG_W'(1);
          cnt_r     <= '0;
          latched_r <= '0;
        end
        ST_MEASURE: begin
          cnt_r <= cnt_r + CNT_W'(1);
          for (int i = 0; i < N_CH; i++) begin
            if (latch_now[i]) begin
              latched_r[i] <= 1'b1;
              time_r[i]    <= cnt_r;
            end
          end
          if (meas_end) begin
            act_r    <= act_fin;
            sum_sh_r <= act_fin;
            wgt_r    <= IDX_W'(1);
            acc_r    <= '0;
            n_r      <= '0;
          end
        end
        ST_SUM: begin
          acc_r    <= acc_nxt;
          n_r      <= n_nxt;
          sum_sh_r <= sum_sh_r >> 1;
          wgt_r    <= wgt_r + IDX_W'(1);
        end
        default: begin
          chg_cnt_r <= '0;
        end
      endcase
    end
  end

  qtr_div_seq #(
    .DVS_W (IDX_W),
    .Q_W   (POS_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_nxt),
    .divisor  (n_nxt),
    .quotient (div_quot),
    .done     (div_done)
  );

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sns_oe_r      <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pos_r         <= '0;
      active_mask_r <= '0;
      line_lost_r   <= 1'b0;
    end else begin
      sns_oe_r <= (state_nxt == ST_CHARGE);
      busy_r   <= (state_nxt != ST_IDLE);
      done_r   <= (state_nxt == ST_DONE);
      if (state_nxt == ST_DONE) begin
        active_mask_r <= act_r;
        if (state_r == ST_DIVIDE) begin
          line_lost_r <= 1'b0;
          pos_r       <= div_quot;
        end else begin
          line_lost_r <= 1'b1;
`ifdef QTR_LOST_HOLD_EN
          pos_r       <= pos_r;
`else
          pos_r       <= '0;
`endif
        end
      end
    end
  end

  assign sns_oe      = {N_CH{sns_oe_r}};
  assign pos         = pos_r;
  assign active_mask = active_mask_r;
  assign line_lost   = line_lost_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_qtr_linea_param.sv
// Scoreboard bench for qtr_linea_param with default parameters. A pad model
// holds each pin high while sns_oe is set and releases it decay[i] cycles
// later; stimulus pushes hand-computed results, a monitor checks each done.
module tb_qtr_linea_param;

  localparam int N_CH       = 8;
  localparam int CNT_W      = 12;
  localparam int CHARGE_CYC = 480;
  localparam int FRAC_W     = 7;
  localparam int POS_W      = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cont;
  logic [CNT_W-1:0] thresh;
  logic [N_CH-1:0]  sns_in = '0;
  logic [N_CH-1:0]  sns_oe;
  logic [POS_W-1:0] pos;
  logic [N_CH-1:0]  active_mask;
  logic             line_lost;
  logic             busy;
  logic             done;

  typedef struct {
    logic [POS_W-1:0] pos;
    logic [N_CH-1:0]  mask;
    logic             lost;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_total = 0;
  int   bc = 0;
  int   off_cnt = 0;
  int   decay [N_CH];

`ifdef QTR_LOST_HOLD_EN
  localparam logic [POS_W-1:0] LOST_POS = 11'd576;
`else
  localparam logic [POS_W-1:0] LOST_POS = 11'd0;
`endif

  qtr_linea_param #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .CHARGE_CYC (CHARGE_CYC),
    .FRAC_W     (FRAC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .thresh      (thresh),
    .sns_in      (sns_in),
    .sns_oe      (sns_oe),
    .pos         (pos),
    .active_mask (active_mask),
    .line_lost   (line_lost),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Pad model: pins driven high while sns_oe, each falls decay[i] cycles after release
  always @(negedge clk) begin
    if (sns_oe[0]) begin
      off_cnt = 0;
      sns_in  = '1;
    end else begin
      off_cnt = off_cnt + 1;
      for (int i = 0; i < N_CH; i++) sns_in[i] = (off_cnt < decay[i]);
    end
  end

  // Monitor: count busy cycles per measurement and score every done pulse
  always @(negedge clk) begin
    if (busy) bc = bc + 1;
    else      bc = 0;
    if (done) begin
      done_total = done_total + 1;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pos", 32'(pos), 32'(mon_e.pos));
        check("active_mask", 32'(active_mask), 32'(mon_e.mask));
        check("line_lost", 32'(line_lost), 32'(mon_e.lost));
        check("busy_cycles", 32'(bc), 32'(mon_e.cyc));
      end
      bc = 0;
    end
  end

  task automatic set_decay(input logic [N_CH-1:0] hi_mask, input int d_hi, input int d_lo);
    for (int i = 0; i < N_CH; i++) decay[i] = hi_mask[i] ? d_hi : d_lo;
  endtask

  task automatic push_exp(input logic [POS_W-1:0] p, input logic [N_CH-1:0] m,
                          input logic l, input int c);
    exp_t e;
    e.pos = p; e.mask = m; e.lost = l; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic run_one(input string name);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle(name, 20000);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int nd;
    int drops;
    int started;
    int n;
    int base;
    rst = 1'b1; start = 1'b0; cont = 1'b0; thresh = 12'd100;
    set_decay(8'h00, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_sns_oe", 32'(sns_oe), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_mask", 32'(active_mask), 32'd0);
    check("rst_lost", 32'(line_lost), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ch3,4 on line: (4+5)*128/2
    set_decay(8'h18, 200, 20);
    push_exp(11'd576, 8'h18, 1'b0, 480 + 202 + 8 + 11 + 1);
    run_one("t1_finish");

    // nothing above threshold: DIVIDE skipped
    set_decay(8'h00, 0, 10);
    push_exp(LOST_POS, 8'h00, 1'b1, 480 + 12 + 8 + 1);
    run_one("t2_finish");

    // no channel decays: counter saturates, all active
    set_decay(8'hFF, 100000, 0);
    push_exp(11'd576, 8'hFF, 1'b0, 480 + 4096 + 8 + 11 + 1);
    run_one("t3_finish");

    // ch0,1,7: floor((1+2+8)*128/3) = 469
    set_decay(8'h83, 200, 20);
    push_exp(11'd469, 8'h83, 1'b0, 480 + 202 + 8 + 11 + 1);
    run_one("t4_finish");

    // thresh 0: every channel active
    thresh = 12'd0;
    set_decay(8'h00, 0, 10);
    push_exp(11'd576, 8'hFF, 1'b0, 480 + 12 + 8 + 11 + 1);
    run_one("t5_finish");
    thresh = 12'd100;

    // continuous mode for three back-to-back measurements
    set_decay(8'h18, 200, 20);
    for (int k = 0; k < 3; k++) push_exp(11'd576, 8'h18, 1'b0, 702);
    @(negedge clk); cont = 1'b1;
    nd = 0; drops = 0; started = 0; n = 0;
    while (nd < 3 && n < 10000) begin
      @(negedge clk);
      n++;
      if (busy) started = 1;
      else if (started != 0) drops++;
      if (done) nd++;
    end
    cont = 1'b0;
    check("cont_dones", 32'(nd), 32'd3);
    check("cont_busy_drops", 32'(drops), 32'd0);
    wait_idle("t6_finish", 2000);
    repeat (3) @(negedge clk);

    // reset in the middle of DIVIDE, then a clean measurement
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (693) @(posedge clk);
    #1;
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_div_sns_oe", 32'(sns_oe), 32'd0);
    check("rst_div_busy", 32'(busy), 32'd0);
    check("rst_div_done", 32'(done), 32'd0);
    check("rst_div_pos", 32'(pos), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(11'd576, 8'h18, 1'b0, 702);
    run_one("t7_finish");

    // start pulsed while busy is ignored
    base = done_total;
    push_exp(11'd576, 8'h18, 1'b0, 702);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle("t8_finish", 20000);
    repeat (20) @(negedge clk);
    check("single_done", 32'(done_total - base), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
